// File: rtl/phase_seq_counter.sv
// Multi-phase light countdown: per-phase programmable durations, advanced on the 1 Hz sec_tick.
// Optional one-shot extension of phase pEXT_PHASE is enabled by defining PHASE_SEQ_EXTEND_EN.
module phase_seq_counter #(
    parameter int pNUM_PHASES  = 3,
    parameter int pCOUNT_WIDTH = 8,
    parameter int pPHASE_WIDTH = $clog2(pNUM_PHASES),
    parameter int pEXT_PHASE   = 2,
    parameter int pEXT_SEC     = 5
) (
    input  logic                                clk,
    input  logic                                rstb,
    input  logic                                en,
    input  logic                                sec_tick,
    input  logic                                hold,
    input  logic [pNUM_PHASES*pCOUNT_WIDTH-1:0] dur_bus,
    input  logic                                force_vld,
    input  logic [pPHASE_WIDTH-1:0]             force_idx,
    input  logic                                ext_req,
    output logic [pPHASE_WIDTH-1:0]             phase_idx,
    output logic [pCOUNT_WIDTH-1:0]             cnt_out,
    output logic                                phase_tick,
    output logic                                cycle_tick,
    output logic                                ext_granted
);

    localparam logic [pPHASE_WIDTH:0]   LP_NUM  = (pPHASE_WIDTH+1)'(pNUM_PHASES);
    localparam logic [pPHASE_WIDTH-1:0] LP_LAST = pPHASE_WIDTH'(pNUM_PHASES - 1);
    localparam logic [pCOUNT_WIDTH-1:0] LP_ONE  = pCOUNT_WIDTH'(1);

    logic [pCOUNT_WIDTH-1:0] w_dur [pNUM_PHASES];

    for (genvar k = 0; k < pNUM_PHASES; k++) begin : g_dur
        assign w_dur[k] = dur_bus[k*pCOUNT_WIDTH +: pCOUNT_WIDTH];
    end

    logic [pPHASE_WIDTH-1:0] r_phase;
    logic [pCOUNT_WIDTH-1:0] r_cnt;
    logic                    r_ptick;
    logic                    r_ctick;
    logic                    r_ext;

    logic                    w_force_ok;
    logic                    w_tick;
    logic                    w_adv;
    logic [pPHASE_WIDTH-1:0] w_nxt_phase;
    logic [pCOUNT_WIDTH-1:0] w_dec;
    logic                    w_ext_ok;
    logic [pCOUNT_WIDTH-1:0] w_ext_cnt;

    // A force steals the tick of its cycle, so the tick never sees a forced count.
    assign w_force_ok  = en & force_vld & ({1'b0, force_idx} < LP_NUM);
    assign w_tick      = en & ~hold & sec_tick & ~w_force_ok;
    assign w_adv       = w_tick & (r_cnt <= LP_ONE);
    assign w_nxt_phase = (r_phase == LP_LAST) ? '0 : r_phase + 1'b1;
    assign w_dec       = r_cnt - LP_ONE;

`ifdef PHASE_SEQ_EXTEND_EN
    logic [pCOUNT_WIDTH-1:0] w_ext_base;
    logic [pCOUNT_WIDTH:0]   w_ext_sum;

    assign w_ext_ok   = en & ~hold & ext_req & ~r_ext & ~w_adv & ~w_force_ok
                        & (r_phase == pPHASE_WIDTH'(pEXT_PHASE));
    // A coincident non-advancing tick still takes its second off before the bonus.
    assign w_ext_base = w_tick ? w_dec : r_cnt;
    assign w_ext_sum  = {1'b0, w_ext_base} + (pCOUNT_WIDTH+1)'(pEXT_SEC);
    assign w_ext_cnt  = w_ext_sum[pCOUNT_WIDTH] ? '1 : w_ext_sum[pCOUNT_WIDTH-1:0];
`else
    logic w_unused_ext;

    assign w_ext_ok     = 1'b0;
    assign w_ext_cnt    = r_cnt;
    assign w_unused_ext = ext_req;
`endif

    always_ff @(posedge clk) begin
        if (rstb) begin
            r_phase <= '0;
            r_cnt   <= w_dur[0];
            r_ptick <= 1'b0;
            r_ctick <= 1'b0;
            r_ext   <= 1'b0;
        end else begin
            r_ptick <= w_adv;
            r_ctick <= w_adv & (r_phase == LP_LAST);
            if (w_force_ok) begin
                r_phase <= force_idx;
                r_cnt   <= w_dur[force_idx];
                r_ext   <= 1'b0;
            end else if (w_adv) begin
                r_phase <= w_nxt_phase;
                r_cnt   <= w_dur[w_nxt_phase];
                r_ext   <= 1'b0;
            end else if (w_ext_ok) begin
                r_cnt   <= w_ext_cnt;
                r_ext   <= 1'b1;
            end else if (w_tick) begin
                r_cnt   <= w_dec;
            end
        end
    end

    assign phase_idx   = r_phase;
    assign cnt_out     = r_cnt;
    assign phase_tick  = r_ptick;
    assign cycle_tick  = r_ctick;
    assign ext_granted = r_ext;

endmodule

// File: doc/phase_seq_counter.md
Name: phase_seq_counter

Overview:
- Parametrised successor to the single-phase light countdown.
- Sequences through pNUM_PHASES light phases, each with its own runtime-programmable duration, and counts each phase down on the 1 Hz sec_tick.
- Issues per-phase and per-cycle tick pulses, and supports hold, forced phase jump and an optional one-shot extension request.
- Sits between the seconds prescaler and the light-output decoder / 7-seg display driver.

Parameters:
- pNUM_PHASES, 3, number of phases in one cycle (legal range 2..16).
- pCOUNT_WIDTH, 8, width of each duration and of the countdown value.
- pPHASE_WIDTH, $clog2(pNUM_PHASES), width of the phase index.
- pEXT_PHASE, 2, index of the only phase that may be extended.
- pEXT_SEC, 5, seconds added per granted extension.

Ports:
- clk  in  1  system clock; the only clock.
- rstb  in  1  synchronous, active-high reset; sampled on rising clk.
- en  in  1  global enable; when low, no state changes except reset.
- sec_tick  in  1  one-clk pulse per second.
- hold  in  1  freezes count and phase while high.
- dur_bus  in  pNUM_PHASES*pCOUNT_WIDTH  phase k duration at bits [k*pCOUNT_WIDTH +: pCOUNT_WIDTH].
- force_vld  in  1  request a jump to force_idx.
- force_idx  in  pPHASE_WIDTH  target phase for a forced jump.
- ext_req  in  1  extension request pulse.
- phase_idx  out  pPHASE_WIDTH  current phase.
- cnt_out  out  pCOUNT_WIDTH  remaining seconds in the current phase.
- phase_tick  out  1  one-clk pulse after each natural phase advance.
- cycle_tick  out  1  one-clk pulse after the wrap from phase pNUM_PHASES-1 to 0.
- ext_granted  out  1  high while the current phase has been extended.

Behaviour:
- Reset (rstb=1 at a clk edge): phase_idx=0, cnt_out=dur[0], phase_tick=0, cycle_tick=0, ext_granted=0. Reset overrides all other inputs.
- A qualifying tick is en & ~hold & sec_tick in a cycle with no accepted force.
- On a qualifying tick:
  - if cnt_out>1: cnt_out decrements by 1.
  - else (cnt_out is 1 or 0): advance. phase_idx becomes (phase_idx+1) mod pNUM_PHASES, cnt_out loads dur[next], ext_granted clears.
- Phase length is max(dur_k,1) seconds. A duration of 0 shows 0 for one second and does not stall the sequence.
- dur_bus is sampled only at load: reset, advance or force. Changing it mid-phase does not affect the running count.
- phase_tick is registered and asserted for exactly one clk in the cycle after an advance edge.
- cycle_tick is asserted in the same cycle as phase_tick when the advance wrapped to phase 0.
- Forced jump:
  - Accepted when en & force_vld & (force_idx < pNUM_PHASES).
  - Loads phase_idx=force_idx and cnt_out=dur[force_idx], and clears ext_granted.
  - No phase_tick or cycle_tick is generated.
  - An out-of-range force_idx is ignored with no state change.
  - A force beats a coincident sec_tick (the tick is dropped) and is accepted even while hold is high.
- Priority: rstb > force > hold/en gating > sec_tick.
- hold high or en low: count, phase and ext_granted are all frozen. Any sec_tick in these cycles is lost, not queued.
- All outputs are registered. There is no combinational path from inputs to outputs.

Optional Feature:
- Macro PHASE_SEQ_EXTEND_EN.
- Defined:
  - On en & ext_req, with phase_idx==pEXT_PHASE, ext_granted=0 and no advance/force/reset in the same cycle: cnt_out += pEXT_SEC, saturating at 2^pCOUNT_WIDTH-1, and ext_granted is set.
  - The extension is granted at most once per phase visit.
  - If ext_req coincides with a non-advancing qualifying tick, the result is cnt_out-1+pEXT_SEC.
- Not defined: ext_req is ignored and ext_granted is tied to 0. Ports remain present.

Test Plan:
- Reset sequence: rstb high 2 clks with dur={15,3,18} for phases 2,1,0 -> phase_idx=0, cnt_out=18, ticks 0. After 18 sec_ticks -> phase_idx=1, cnt_out=3, phase_tick one clk. After 3+15 more -> phase_idx=0, cycle_tick with phase_tick.
- Zero duration: dur[1]=0 -> phase 1 shows cnt_out=0 for exactly one sec_tick, then advances to phase 2 normally.
- Hold and enable: hold high across 4 sec_ticks at cnt_out=10 -> cnt_out stays 10 and phase is unchanged. Repeat with en low -> same result.
- Forced jump: force_vld with force_idx=2 coincident with sec_tick at phase 0, cnt_out=5 -> phase_idx=2, cnt_out=dur[2], no phase_tick. Repeat with force_idx=3 (pNUM_PHASES=3) -> no change.
- Mid-phase reset: rstb asserted at phase 1, cnt_out=2 -> next clk phase_idx=0, cnt_out=dur[0], all pulses low.
- Extension (PHASE_SEQ_EXTEND_EN): in phase 2 at cnt_out=7, ext_req -> cnt_out=12, ext_granted=1. Second ext_req -> no change. At cnt_out=253 with pCOUNT_WIDTH=8 -> saturates at 255.
